// File: rtl/output_img.sv
// Raster stream sink: checks pixels/line and lines/frame against H_ACT/V_ACT, sums pixels, publishes per-frame results.
// Results land 2 edges after inV drops; frame_done pulses one cycle.
// No backpressure: one pixel accepted per clock unconditionally.
module output_img #(
    parameter int H_ACT = 2448,
    parameter int V_ACT = 2048,
    parameter int DW    = 12
`ifdef OUTPUT_IMG_DUMP_EN
    , parameter string OUTFILE_NAME = "out_image.mem"
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inV,
    input  logic          inH,
    input  logic [DW-1:0] inDATA,
    output logic          frame_done,
    output logic [15:0]   frame_cnt,
    output logic [15:0]   line_cnt,
    output logic [15:0]   last_width,
    output logic          h_err,
    output logic          v_err,
    output logic [31:0]   checksum
);

    localparam logic [15:0] H16 = 16'(H_ACT);
    localparam logic [15:0] V16 = 16'(V_ACT);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t        state, stateNext;
    logic          vQ, hQ, vQQ, hQQ;
    logic [DW-1:0] dQ;
    logic          armed;
    logic [15:0]   pixCnt, lineWk, widthWk;
    logic          hErrWk;
    logic [31:0]   sumWk;
    logic          vRise, vFall, hFall, pixVld, start, finish;
    logic          lineClose, lineCount, pixTake;
    logic [15:0]   lineNext, widthNext;
    logic          hErrNext;

    // armed blocks a frame whose inV was already high when reset released
    assign vRise  = vQ & ~vQQ & armed;
    assign vFall  = ~vQ & vQQ;
    assign hFall  = ~hQ & hQQ;
    assign pixVld = vQ & hQ;

    always_ff @(posedge clk) begin
        if (rst) begin
            vQ    <= 1'b0;
            hQ    <= 1'b0;
            vQQ   <= 1'b0;
            hQQ   <= 1'b0;
            dQ    <= '0;
            armed <= 1'b0;
        end else begin
            vQ    <= inV;
            hQ    <= inH;
            vQQ   <= vQ;
            hQQ   <= hQ;
            dQ    <= inDATA;
            armed <= armed | ~inV;
        end
    end

    always_comb begin
        stateNext = state;
        start     = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (vRise) begin
                    stateNext = ACTIVE;
                    start     = 1'b1;
                end
            end
            ACTIVE: begin
                if (vFall) begin
                    stateNext = DONE;
                    finish    = 1'b1;
                end
            end
            DONE: begin
                if (vRise) begin
                    stateNext = ACTIVE;
                    start     = 1'b1;
                end else begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    // Line-close contribution is folded in combinationally so the closing line is visible when results load
    always_comb begin
        lineClose = (state == ACTIVE) & (hFall | (vFall & hQ));
        lineCount = lineClose & (pixCnt != 16'd0);
        lineNext  = lineWk;
        widthNext = widthWk;
        hErrNext  = hErrWk;
        if (lineCount) begin
            lineNext  = (lineWk == 16'hFFFF) ? lineWk : lineWk + 16'd1;
            widthNext = pixCnt;
            hErrNext  = hErrWk | (pixCnt != H16);
        end
    end

    assign pixTake = pixVld & (start | (state == ACTIVE));

    always_ff @(posedge clk) begin
        if (rst) begin
            pixCnt  <= '0;
            lineWk  <= '0;
            widthWk <= '0;
            hErrWk  <= 1'b0;
            sumWk   <= '0;
        end else if (start) begin
            pixCnt  <= pixVld ? 16'd1 : 16'd0;
            sumWk   <= pixVld ? 32'(dQ) : 32'd0;
            lineWk  <= '0;
            widthWk <= '0;
            hErrWk  <= 1'b0;
        end else if (state == ACTIVE) begin
            if (lineClose)
                pixCnt <= '0;
            else if (pixVld && pixCnt != 16'hFFFF)
                pixCnt <= pixCnt + 16'd1;
            if (pixVld)
                sumWk <= sumWk + 32'(dQ);
            lineWk  <= lineNext;
            widthWk <= widthNext;
            hErrWk  <= hErrNext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt  <= '0;
            line_cnt   <= '0;
            last_width <= '0;
            h_err      <= 1'b0;
            v_err      <= 1'b0;
            checksum   <= '0;
        end else if (finish) begin
            frame_cnt  <= frame_cnt + 16'd1;
            line_cnt   <= lineNext;
            last_width <= widthNext;
            h_err      <= hErrNext;
            v_err      <= (lineNext != V16);
            checksum   <= sumWk;
        end
    end

    assign frame_done = (state == DONE);

endmodule

// File: tb/tb_output_img.sv
// Directed frames with hand-computed results; expected frame records queue up and a monitor checks them on each frame_done.
module tb_output_img;

    logic        clk = 1'b0;
    logic        rst;
    logic        inV, inH;
    logic [11:0] inDATA;
    logic        frame_done;
    logic [15:0] frame_cnt, line_cnt, last_width;
    logic        h_err, v_err;
    logic [31:0] checksum;

    output_img #(.H_ACT(8), .V_ACT(4), .DW(12)) dut (
        .clk(clk), .rst(rst), .inV(inV), .inH(inH), .inDATA(inDATA),
        .frame_done(frame_done), .frame_cnt(frame_cnt), .line_cnt(line_cnt),
        .last_width(last_width), .h_err(h_err), .v_err(v_err), .checksum(checksum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] fc, lc, lw;
        logic        he, ve;
        logic [31:0] cs;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mexp;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    int   wid[8];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic drive(input logic v, input logic h, input logic [11:0] d);
        inV = v; inH = h; inDATA = d;
        @(negedge clk);
    endtask

    task automatic checkZero();
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_frame_cnt", 32'(frame_cnt), 0);
        chk("rst_line_cnt", 32'(line_cnt), 0);
        chk("rst_last_width", 32'(last_width), 0);
        chk("rst_h_err", 32'(h_err), 0);
        chk("rst_v_err", 32'(v_err), 0);
        chk("rst_checksum", checksum, 0);
    endtask

    // fixedVal < 0 means incrementing pixel values starting at 1
    task automatic sendFrame(input int nl, input int fixedVal, input bit hEnd, input int gap, input exp_t e);
        int val;
        val = 1;
        drive(1'b1, 1'b0, 12'h0);
        for (int l = 0; l < nl; l++) begin
            for (int p = 0; p < wid[l]; p++) begin
                drive(1'b1, 1'b1, (fixedVal >= 0) ? 12'(fixedVal) : 12'(val));
                val++;
            end
            if (l != nl - 1) drive(1'b1, 1'b0, 12'h0);
        end
        e.cyc = cyc + 2;
        sb.push_back(e);
        drive(1'b0, hEnd, 12'h0);
        for (int g = 1; g < gap; g++) drive(1'b0, 1'b0, 12'h0);
    endtask

    function automatic exp_t mk(input int fc, input int lc, input int lw, input bit he, input bit ve, input int cs);
        exp_t e;
        e.fc = 16'(fc); e.lc = 16'(lc); e.lw = 16'(lw);
        e.he = he; e.ve = ve; e.cs = 32'(cs); e.cyc = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && frame_done) begin
            if (sb.size() == 0) begin
                chk("unexpected_frame_done", 32'd1, 32'd0);
            end else begin
                mexp = sb.pop_front();
                chk("done_latency", 32'(cyc), 32'(mexp.cyc));
                chk("frame_cnt", 32'(frame_cnt), 32'(mexp.fc));
                chk("line_cnt", 32'(line_cnt), 32'(mexp.lc));
                chk("last_width", 32'(last_width), 32'(mexp.lw));
                chk("h_err", 32'(h_err), 32'(mexp.he));
                chk("v_err", 32'(v_err), 32'(mexp.ve));
                chk("checksum", checksum, mexp.cs);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; inV = 1'b0; inH = 1'b0; inDATA = '0;
        @(negedge clk);
        repeat (3) drive(1'b0, 1'b0, 12'h0);
        checkZero();
        rst = 1'b0;
        repeat (3) drive(1'b0, 1'b0, 12'h0);

        // nominal 4x8, values 1..32
        wid = '{8, 8, 8, 8, 0, 0, 0, 0};
        sendFrame(4, -1, 1'b0, 3, mk(1, 4, 8, 1'b0, 1'b0, 528));
        // short third line, values 1..31
        wid = '{8, 8, 7, 8, 0, 0, 0, 0};
        sendFrame(4, -1, 1'b0, 3, mk(2, 4, 8, 1'b1, 1'b0, 496));
        wid = '{8, 8, 8, 8, 0, 0, 0, 0};
        sendFrame(4, -1, 1'b0, 3, mk(3, 4, 8, 1'b0, 1'b0, 528));
        // five lines, values 1..40
        wid = '{8, 8, 8, 8, 8, 0, 0, 0};
        sendFrame(5, -1, 1'b0, 3, mk(4, 5, 8, 1'b0, 1'b1, 820));
        // inV falls while inH still high
        wid = '{8, 8, 8, 8, 0, 0, 0, 0};
        sendFrame(4, -1, 1'b1, 3, mk(5, 4, 8, 1'b0, 1'b0, 528));
        // one 65537-pixel line of 12'hFFF: width saturates, sum = 0x0FFF0FFF
        wid = '{65537, 0, 0, 0, 0, 0, 0, 0};
        sendFrame(1, 4095, 1'b0, 3, mk(6, 1, 16'hFFFF, 1'b1, 1'b1, 32'h0FFF0FFF));

        // reset mid-frame, with inV held high across reset release
        drive(1'b1, 1'b0, 12'h0);
        for (int p = 0; p < 5; p++) drive(1'b1, 1'b1, 12'(p + 1));
        rst = 1'b1;
        drive(1'b1, 1'b1, 12'h7);
        drive(1'b1, 1'b1, 12'h7);
        checkZero();
        rst = 1'b0;
        for (int p = 0; p < 8; p++) drive(1'b1, 1'b1, 12'h5);
        drive(1'b1, 1'b0, 12'h0);
        repeat (4) drive(1'b0, 1'b0, 12'h0);
        chk("no_done_after_rst", 32'(frame_cnt), 32'd0);

        // back-to-back frames with 1-cycle inV gaps
        wid = '{8, 8, 8, 8, 0, 0, 0, 0};
        sendFrame(4, -1, 1'b0, 1, mk(1, 4, 8, 1'b0, 1'b0, 528));
        sendFrame(4, -1, 1'b0, 1, mk(2, 4, 8, 1'b0, 1'b0, 528));
        sendFrame(4, -1, 1'b0, 3, mk(3, 4, 8, 1'b0, 1'b0, 528));

        repeat (10) drive(1'b0, 1'b0, 12'h0);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        chk("final_frame_cnt", 32'(frame_cnt), 32'd3);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
